// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// 32 iterations plus one sign-fix cycle; also services MTHI/MTLO.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
  logic            is_div;
  logic            sign_rs;
  logic            sign_rt;
  logic            div_zero;

  logic             issue_c;
  logic             is_signed_c;
  logic [WIDTH-1:0] mag_rs_c;
  logic [WIDTH-1:0] mag_rt_c;
  logic [WIDTH:0]   add_sum_c;
  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH:0]   rem_diff_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

  assign issue_c     = (state == S_IDLE) && start && !cancel;
  assign is_signed_c = (op == OP_MULT) || (op == OP_DIV);
  assign mag_rs_c    = (is_signed_c && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign mag_rt_c    = (is_signed_c && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // One iteration of each algorithm, evaluated every cycle
  assign add_sum_c   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
  assign rem_shift_c = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff_c  = rem_shift_c - {1'b0, opb};

  assign prod_fix_c = (sign_rs ^ sign_rt) ? -acc : acc;
  assign quot_c     = (sign_rs ^ sign_rt) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_c      = sign_rs ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (issue_c && !op[2]) state_next = S_RUN;
      S_RUN: begin
        if (cancel)                        state_next = S_IDLE;
        else if (cnt == CW'(WIDTH - 1))    state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      sign_rs  <= 1'b0;
      sign_rt  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_c) begin
            if (op == OP_MTHI) hi <= rs_val;
            if (op == OP_MTLO) lo <= rs_val;
            if (!op[2]) begin
              cnt      <= '0;
              is_div   <= op[1];
              sign_rs  <= is_signed_c & rs_val[WIDTH-1];
              sign_rt  <= is_signed_c & rt_val[WIDTH-1];
              div_zero <= op[1] && (rt_val == '0);
              if (op[1]) begin
                acc <= {{WIDTH{1'b0}}, mag_rs_c};
                opb <= mag_rt_c;
              end else begin
                acc <= {{WIDTH{1'b0}}, mag_rt_c};
                opb <= mag_rs_c;
              end
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (!is_div)            acc <= {add_sum_c, acc[WIDTH-1:1]};
          else if (!rem_diff_c[WIDTH])
            acc <= {rem_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {rem_shift_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        S_FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix_c;
            end else begin
              hi <= rem_c;
              lo <= div_zero ? '1 : quot_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after the start edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
  endtask

  // Counts busy cycles, bounded so a stuck unit cannot hang the run
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    issue(3'b000, 32'hFFFFFFFD, 32'd5);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 33", n); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_m1_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL mult_m1_lo got %h exp 1", lo); end
  endtask

  task automatic test_div();
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done got %b exp 1", done); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    issue(3'b011, 32'd100, 32'd0);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL divz_busy_cycles got %0d exp 33", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL divz_done got %b exp 1", done); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
    checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divz_hi got %h exp 00000064", hi); end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h exp 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divmin_hi got %h exp 0", hi); end
    issue(3'b011, 32'd1000, 32'd7);
    wait_idle(n);
    checks++; if (lo !== 32'd142) begin errors++; $display("FAIL divu_lo got %h exp 0000008e", lo); end
    checks++; if (hi !== 32'd6) begin errors++; $display("FAIL divu_hi got %h exp 00000006", hi); end
  endtask

  task automatic test_mthi_mtlo();
    step();
    start = 1'b1; op = 3'b100; rs_val = 32'h12345678; rt_val = '0;
    step();
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy=%b done=%b exp 0 0", busy, done); end
    op = 3'b101; rs_val = 32'h9ABCDEF0;
    step();
    start = 1'b0;
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got %h exp 9abcdef0", lo); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi_keep got %h exp 12345678", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags got busy=%b done=%b exp 0 0", busy, done); end
    issue(3'b001, 32'd2, 32'd3);
    issue(3'b100, 32'hDEADBEEF, 32'd0);
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_busy_hi got %h exp 12345678", hi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mthi_busy_busy got %b exp 1", busy); end
    wait_idle(n);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mthi_busy_res_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL mthi_busy_res_lo got %h exp 6", lo); end
  endtask

  task automatic test_cancel();
    issue(3'b011, 32'd1000, 32'd7);
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0 || lo !== 32'd6) begin errors++; $display("FAIL cancel_hilo got %h_%h exp 00000000_00000006", hi, lo); end
    issue(3'b001, 32'h00010000, 32'h00010000);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_no_done got %b exp 0", done); end
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL post_cancel_cycles got %0d exp 33", n); end
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL post_cancel_hilo got %h_%h exp 00000001_00000000", hi, lo); end
    start = 1'b1; cancel = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd3;
    step();
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_cancel_busy got %b exp 0", busy); end
    issue(3'b110, 32'h55555555, 32'd1);
    step();
    checks++; if (busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL op11x got busy=%b hilo=%h_%h exp 0 00000001_00000000", busy, hi, lo); end
  endtask

  task automatic test_reset_mid();
    issue(3'b000, 32'd7, 32'hFFFFFFFE);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h_%h exp 0_0", hi, lo); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_after_busy got %b exp 0", busy); end
    issue(3'b000, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL midrst_cycles got %0d exp 33", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL midrst_res got %h_%h exp ffffffff_fffffff2", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_mthi_mtlo();
    test_cancel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
